// File: rtl/jala_trace_buffer.sv
// jala_trace_buffer
// Instruction-trace capture FIFO fed by the CPU debug port (CurrentState, PC, IR).
// One {PC, IR} entry is recorded each time the control unit enters CAPTURE_STATE.
// A host reader drains the entries over a show-ahead valid/ready interface.
// Dropped captures are flagged (sticky Overflow) and counted (saturating DropCount).
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   : a 16-bit free-running cycle counter is added and entries become
//               {Timestamp, PC, IR} (48 bits)
//   undefined : entries are {PC, IR} (32 bits)
module jala_trace_buffer #(
    parameter int         DEPTH         = 16,
    parameter logic [4:0] CAPTURE_STATE = 5'd1,
    localparam int        AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int        CW            = AW + 1,
`ifdef TRACE_TIMESTAMP_EN
    localparam int        ENTRY_W       = 48
`else
    localparam int        ENTRY_W       = 32
`endif
) (
    input  logic               CLK,
    input  logic               CtrlRst_n,
    input  logic               Enable,
    input  logic               Flush,
    input  logic [4:0]         CurrentState,
    input  logic [15:0]        PCIn,
    input  logic [15:0]        IRIn,
    output logic               TrcValid,
    input  logic               TrcReady,
    output logic [ENTRY_W-1:0] TrcData,
    output logic [CW-1:0]      Count,
    output logic               Overflow,
    output logic [7:0]         DropCount
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Saturating increment for the drop counter: sticks at 255.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Pointer advance; DEPTH is a power of two so the wrap is the natural overflow.
    function automatic logic [AW-1:0] ptrNext(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic               matchNow;
    logic               matchPrev_p1;
    logic               captureEv;
    logic               isFull;
    logic               doPop;
    logic               doWrite;
    logic               dropEv;
    logic               memWe;
    logic [CW-1:0]      countNext;
    logic [ENTRY_W-1:0] newEntry;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]        timestamp;

    // Free-running cycle counter; only reset clears it, Flush leaves it running.
    always_ff @(posedge CLK) begin
        if (!CtrlRst_n) begin
            timestamp <= 16'd0;
        end else begin
            timestamp <= timestamp + 16'd1;
        end
    end

    assign newEntry = {timestamp, PCIn, IRIn};
`else
    assign newEntry = {PCIn, IRIn};
`endif

    assign matchNow  = (CurrentState == CAPTURE_STATE);
    assign captureEv = Enable && matchNow && !matchPrev_p1;
    assign TrcValid  = (Count != '0);
    assign isFull    = (Count == FULL_COUNT);
    assign doPop     = TrcValid && TrcReady;
    // A full FIFO still accepts a capture when a pop frees the head slot on the same edge.
    assign doWrite   = captureEv && (!isFull || doPop);
    assign dropEv    = captureEv && isFull && !doPop;
    assign memWe     = CtrlRst_n && !Flush && doWrite;
    assign TrcData   = mem[rdPtr];

    // Entry-edge detector: tracks the state every cycle, including during reset and
    // Flush, so a state held through reset is not mistaken for a fresh entry.
    always_ff @(posedge CLK) begin
        matchPrev_p1 <= matchNow;
    end

    // Next occupancy from the accepted write and the pop of this cycle.
    always_comb begin
        countNext = Count;
        case ({doWrite, doPop})
            2'b10:   countNext = Count + CW'(1);
            2'b01:   countNext = Count - CW'(1);
            default: countNext = Count;
        endcase
    end

    // Entry storage: data only, never reset; writes are blocked on reset and Flush edges.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[wrPtr] <= newEntry;
        end
    end

    // FIFO control and error status: reset has priority over Flush, Flush over capture/pop.
    always_ff @(posedge CLK) begin
        if (!CtrlRst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            DropCount <= 8'd0;
        end else if (Flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            DropCount <= 8'd0;
        end else begin
            if (doWrite) begin
                wrPtr <= ptrNext(wrPtr);
            end
            if (doPop) begin
                rdPtr <= ptrNext(rdPtr);
            end
            Count <= countNext;
            if (dropEv) begin
                Overflow  <= 1'b1;
                DropCount <= satInc8(DropCount);
            end
        end
    end

endmodule

// File: tb/tb_jala_trace_buffer.sv
// Testbench for jala_trace_buffer: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a decoupled output monitor.
// Build with +define+TRACE_TIMESTAMP_EN to exercise the timestamp variant.
module tb_jala_trace_buffer;

    localparam int         DEPTH = 16;
    localparam logic [4:0] CAP   = 5'd1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int         EW    = 48;
`else
    localparam int         EW    = 32;
`endif

    logic          CLK = 1'b0;
    logic          CtrlRst_n = 1'b0;
    logic          Enable = 1'b0;
    logic          Flush = 1'b0;
    logic [4:0]    CurrentState = CAP;
    logic [15:0]   PCIn = 16'h0010;
    logic [15:0]   IRIn = 16'hA123;
    logic          TrcReady = 1'b0;
    logic          TrcValid;
    logic [EW-1:0] TrcData;
    logic [4:0]    Count;
    logic          Overflow;
    logic [7:0]    DropCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [EW-1:0] expQ[$];
    logic          mOverflow = 1'b0;
    int            mDrops = 0;
    logic          mPrevMatch = 1'b0;
    logic [15:0]   mTs = 16'd0;

    jala_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_STATE(CAP)) dut (
        .CLK(CLK),
        .CtrlRst_n(CtrlRst_n),
        .Enable(Enable),
        .Flush(Flush),
        .CurrentState(CurrentState),
        .PCIn(PCIn),
        .IRIn(IRIn),
        .TrcValid(TrcValid),
        .TrcReady(TrcReady),
        .TrcData(TrcData),
        .Count(Count),
        .Overflow(Overflow),
        .DropCount(DropCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: status every cycle, head entry whenever valid, pop on handshake
    always @(negedge CLK) begin
        chk("count", 64'(Count), 64'(expQ.size()));
        chk("valid", 64'(TrcValid), 64'(expQ.size() != 0));
        chk("overflow", 64'(Overflow), 64'(mOverflow));
        chk("dropcount", 64'(DropCount), 64'(mDrops));
        if (TrcValid === 1'b1 && expQ.size() != 0) begin
            chk("head_data", 64'(TrcData), 64'(expQ[0]));
            if (TrcReady) begin
                void'(expQ.pop_front());
            end
        end
    end

    // Reference model: applies the inputs that the next rising edge will see
    always begin
        @(negedge CLK);
        #1;
        if (!CtrlRst_n) begin
            expQ.delete();
            mOverflow = 1'b0;
            mDrops = 0;
            mTs = 16'd0;
        end else if (Flush) begin
            expQ.delete();
            mOverflow = 1'b0;
            mDrops = 0;
            mTs = mTs + 16'd1;
        end else begin
            if (Enable && CurrentState == CAP && !mPrevMatch) begin
                if (expQ.size() < DEPTH) begin
`ifdef TRACE_TIMESTAMP_EN
                    expQ.push_back({mTs, PCIn, IRIn});
`else
                    expQ.push_back({PCIn, IRIn});
`endif
                end else begin
                    mOverflow = 1'b1;
                    if (mDrops < 255) mDrops = mDrops + 1;
                end
            end
            mTs = mTs + 16'd1;
        end
        mPrevMatch = (CurrentState == CAP);
    end

    task automatic drive(input logic rst_n, input logic en, input logic fl, input logic rdy,
                         input logic [4:0] st, input logic [15:0] pc, input logic [15:0] ir);
        @(posedge CLK);
        #2;
        CtrlRst_n = rst_n;
        Enable = en;
        Flush = fl;
        TrcReady = rdy;
        CurrentState = st;
        PCIn = pc;
        IRIn = ir;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b1, 1'b1, 1'b0, rdy, 5'd0, 16'($urandom), 16'($urandom));
    endtask

    task automatic capture(input logic rdy);
        drive(1'b1, 1'b1, 1'b0, rdy, CAP, 16'($urandom), 16'($urandom));
    endtask

    // Observe the state left by the last driven inputs
    task automatic checkpoint();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset held in CAPTURE_STATE, release while still there
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, CAP, 16'h0010, 16'hA123);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, CAP, 16'h0010, 16'hA123);
        checkpoint();
        chk("no_capture_after_reset", 64'(Count), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0010, 16'hA123);
        drive(1'b1, 1'b1, 1'b0, 1'b0, CAP, 16'h0010, 16'hA123);
        idle(1'b0);
        checkpoint();
        chk("first_entry_count", 64'(Count), 64'd1);
        chk("first_entry_valid", 64'(TrcValid), 64'd1);
        chk("first_entry_data", 64'(TrcData[31:0]), 64'h0010A123);

        // Dwell in CAPTURE_STATE for 5 cycles
        for (int i = 0; i < 5; i++) capture(1'b0);
        idle(1'b0);
        checkpoint();
        chk("dwell_one_entry", 64'(Count), 64'd2);

        // Drain
        for (int i = 0; i < 3; i++) idle(1'b1);
        idle(1'b0);
        checkpoint();
        chk("drained_valid", 64'(TrcValid), 64'd0);

        // Enable raised while already in CAPTURE_STATE
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, CAP, 16'h1111, 16'h2222);
        for (int i = 0; i < 2; i++) capture(1'b0);
        idle(1'b0);
        checkpoint();
        chk("late_enable_no_capture", 64'(Count), 64'd0);

        // Fill and overflow: 18 capture events
        for (int i = 0; i < 18; i++) begin
            capture(1'b0);
            idle(1'b0);
        end
        checkpoint();
        chk("fill_count", 64'(Count), 64'd16);
        chk("fill_overflow", 64'(Overflow), 64'd1);
        chk("fill_drops", 64'(DropCount), 64'd2);

        // Simultaneous capture and pop at full
        drive(1'b1, 1'b1, 1'b0, 1'b1, CAP, 16'hBEEF, 16'h1234);
        idle(1'b0);
        checkpoint();
        chk("full_simul_count", 64'(Count), 64'd16);
        chk("full_simul_drops", 64'(DropCount), 64'd2);
        for (int i = 0; i < 15; i++) idle(1'b1);
        idle(1'b0);
        checkpoint();
        chk("newest_last", 64'(TrcData[31:0]), 64'hBEEF1234);
        idle(1'b1);
        idle(1'b0);
        checkpoint();
        chk("drain_all_valid", 64'(TrcValid), 64'd0);

        // Simultaneous capture and pop while empty
        capture(1'b1);
        idle(1'b0);
        checkpoint();
        chk("empty_simul_count", 64'(Count), 64'd1);
        idle(1'b1);

        // Flush with a coincident capture while holding 5 entries and Overflow
        for (int i = 0; i < 17; i++) begin
            capture(1'b0);
            idle(1'b0);
        end
        for (int i = 0; i < 11; i++) idle(1'b1);
        idle(1'b0);
        checkpoint();
        chk("preflush_count", 64'(Count), 64'd5);
        chk("preflush_overflow", 64'(Overflow), 64'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, CAP, 16'h5555, 16'h6666);
        idle(1'b0);
        checkpoint();
        chk("flush_count", 64'(Count), 64'd0);
        chk("flush_overflow", 64'(Overflow), 64'd0);
        chk("flush_drops", 64'(DropCount), 64'd0);
        chk("flush_valid", 64'(TrcValid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < (i < 400 ? 2 : 6)),
                  ($urandom_range(0, 9) < 4) ? CAP : 5'($urandom_range(2, 31)),
                  16'($urandom), 16'($urandom));
        end
        idle(1'b0);

`ifdef TRACE_TIMESTAMP_EN
        // Timestamps at cycles 3 and 70000 after reset
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, CAP, 16'h0003, 16'h0003);
        for (int i = 0; i < 69996; i++) idle(1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, CAP, 16'h7000, 16'h7000);
        idle(1'b0);
        checkpoint();
        chk("ts_first", 64'(TrcData[47:32]), 64'h0003);
        idle(1'b1);
        idle(1'b0);
        checkpoint();
        chk("ts_wrapped", 64'(TrcData[47:32]), 64'h1170);
`endif

        for (int i = 0; i < 4; i++) idle(1'b1);
        checkpoint();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
